// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard/stall/flush controller for the 4-stage pipeline; optional counters under HAZARD_PERF_CNT_EN
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter logic [3:0]  OP_LOAD    = 4'hA,
  parameter logic [3:0]  OP_BR      = 4'hB,
  parameter logic [3:0]  OP_MUL     = 4'hC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] id_inst,
  input  logic [15:0] ex_inst,
  input  logic        ex_branch_taken,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_hold,
  output logic        busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;

  // Number of MUL_WAIT cycles: the entry cycle in RUN also holds EX, and the
  // final occupancy cycle is the normal advance cycle.
  localparam logic [3:0] MUL_WAIT_LEN = 4'(MUL_CYCLES - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  // Set for the advance cycle after a MUL finishes: the same MUL is still in
  // EX that cycle and must not be mistaken for a new one.
  logic       mul_done, mul_done_nxt;

  logic [3:0] id_op, id_rs1, id_rs2, ex_op, ex_rd;
  logic       br_taken, mul_entry, load_use;

  assign id_op  = id_inst[15:12];
  assign id_rs1 = id_inst[7:4];
  assign id_rs2 = id_inst[3:0];
  assign ex_op  = ex_inst[15:12];
  assign ex_rd  = ex_inst[11:8];

  assign br_taken  = (ex_op == OP_BR) && ex_branch_taken;
  assign mul_entry = (ex_op == OP_MUL) && !mul_done;
  assign load_use  = (ex_op == OP_LOAD) && (ex_rd != 4'd0) && (id_op != 4'd0) &&
                     ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

  // State, counter and post-MUL flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= 4'd0;
      mul_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mul_done <= mul_done_nxt;
    end
  end

  // Next-state: enter MUL_WAIT on a new MUL, count down the remaining wait cycles
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mul_done_nxt = 1'b0;
    case (state)
      RUN: begin
        if (!br_taken && mul_entry) begin
          if (MUL_WAIT_LEN == 4'd0) begin
            mul_done_nxt = 1'b1;
          end else begin
            state_nxt = MUL_WAIT;
            cnt_nxt   = MUL_WAIT_LEN;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt    = RUN;
          cnt_nxt      = 4'd0;
          mul_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Mealy outputs: branch beats MUL entry beats load-use; all zero in reset
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (mul_entry) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            ex_hold     = 1'b1;
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        MUL_WAIT: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          ex_hold     = 1'b1;
          busy        = 1'b1;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of stall and flush cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (pc_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (if_id_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] id_inst = 16'h0000;
  logic [15:0] ex_inst = 16'h0000;
  logic        ex_branch_taken = 1'b0;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
  logic [15:0] m_stall = 16'd0;
  logic [15:0] m_flush = 16'd0;
`endif

  pipe_hazard_ctrl #(.MUL_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .id_inst(id_inst),
    .ex_inst(ex_inst),
    .ex_branch_taken(ex_branch_taken),
    .pc_stall(pc_stall),
    .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .ex_hold(ex_hold),
    .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, busy}
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] LU = 6'b110100;
  localparam logic [5:0] BR = 6'b001100;
  localparam logic [5:0] ME = 6'b110010;
  localparam logic [5:0] MW = 6'b110011;

  typedef struct packed {
    logic       rst;
    logic [5:0] ctl;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic [5:0] got;
  int checks = 0;
  int errors = 0;
  int tag_n  = 0;

  task automatic drive(input logic r, input logic [15:0] id, input logic [15:0] ex,
                       input logic br, input logic [5:0] e);
    @(posedge clk);
    #1;
    reset           = r;
    id_inst         = id;
    ex_inst         = ex;
    ex_branch_taken = br;
    exp_q.push_back(exp_t'{rst: r, ctl: e, tag: tag_n});
    tag_n++;
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      got = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, busy};
      checks++;
      if (got !== cur.ctl) begin
        errors++;
        $display("FAIL ctl step %0d: got %b want %b", cur.tag, got, cur.ctl);
      end
      checks++;
      if (if_id_flush && if_id_stall) begin
        errors++;
        $display("FAIL flush_vs_stall step %0d: got flush=1 stall=1 want not both", cur.tag);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (cur.rst) begin
        m_stall = 16'd0;
        m_flush = 16'd0;
      end
      checks++;
      if (stall_cnt !== m_stall) begin
        errors++;
        $display("FAIL stall_cnt step %0d: got %h want %h", cur.tag, stall_cnt, m_stall);
      end
      checks++;
      if (flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL flush_cnt step %0d: got %h want %h", cur.tag, flush_cnt, m_flush);
      end
      if (!cur.rst) begin
        if (cur.ctl[5] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (cur.ctl[3] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      end
`endif
    end
  end

  initial begin
    // Reset holds every output low even with hazards on the inputs
    drive(1, 16'h1530, 16'hA312, 0, Z);
    drive(1, 16'h1530, 16'hC412, 1, Z);
    // Load-use on rs1, then NOP in EX clears it
    drive(0, 16'h1530, 16'hA312, 0, LU);
    drive(0, 16'h1530, 16'h0000, 0, Z);
    // No false hazards: rd=r0, and NOP in ID
    drive(0, 16'h1500, 16'hA012, 0, Z);
    drive(0, 16'h0000, 16'hA312, 0, Z);
    // Load-use on rs2, and a non-LOAD producer
    drive(0, 16'h1203, 16'hA312, 0, LU);
    drive(0, 16'h1530, 16'h1312, 0, Z);
    // Taken branch flushes; untaken branch does nothing
    drive(0, 16'h1530, 16'hB000, 1, BR);
    drive(0, 16'h1530, 16'hB000, 0, Z);
    // MUL: entry, two waits (taken branch ignored), advance cycle, then RUN
    drive(0, 16'h1530, 16'hC412, 0, ME);
    drive(0, 16'h1530, 16'hC412, 1, MW);
    drive(0, 16'h1530, 16'hC412, 0, MW);
    drive(0, 16'h1530, 16'hC412, 0, Z);
    drive(0, 16'h1530, 16'h0000, 0, Z);
    // Back-to-back MULs
    drive(0, 16'hC123, 16'hC412, 0, ME);
    drive(0, 16'hC123, 16'hC412, 0, MW);
    drive(0, 16'hC123, 16'hC412, 0, MW);
    drive(0, 16'h1000, 16'hC412, 0, Z);
    drive(0, 16'h1000, 16'hC123, 0, ME);
    drive(0, 16'h1000, 16'hC123, 0, MW);
    drive(0, 16'h1000, 16'hC123, 0, MW);
    drive(0, 16'h1000, 16'hC123, 0, Z);
    // Load-use against a MUL in ID
    drive(0, 16'hC134, 16'hA312, 0, LU);
    // Reset in the second MUL_WAIT cycle aborts; fresh MUL afterwards
    drive(0, 16'h1530, 16'hC412, 0, ME);
    drive(0, 16'h1530, 16'hC412, 0, MW);
    drive(1, 16'h1530, 16'hC412, 0, Z);
    drive(0, 16'h1530, 16'hC412, 0, ME);
    drive(0, 16'h1530, 16'hC412, 0, MW);
    drive(0, 16'h1530, 16'hC412, 0, MW);
    drive(0, 16'h1530, 16'hC412, 0, Z);
    drive(0, 16'h1530, 16'h0000, 0, Z);
`ifdef HAZARD_PERF_CNT_EN
    // Counters: MUL plus one branch from reset gives 3 stalls, 1 flush
    drive(1, 16'h0000, 16'h0000, 0, Z);
    drive(0, 16'h1530, 16'hC412, 0, ME);
    drive(0, 16'h1530, 16'hC412, 0, MW);
    drive(0, 16'h1530, 16'hC412, 0, MW);
    drive(0, 16'h1530, 16'hC412, 0, Z);
    drive(0, 16'h1530, 16'hB000, 1, BR);
    drive(0, 16'h0000, 16'h0000, 0, Z);
    // Saturation of the stall counter
    for (int i = 0; i < 65540; i++) drive(0, 16'h1530, 16'hA312, 0, LU);
    drive(0, 16'h0000, 16'h0000, 0, Z);
    drive(0, 16'h0000, 16'h0000, 0, Z);
`endif
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
